bch_decode_arbiter: RTL

Shares one serial BCH decoder (N, K, T instance) between R requesters. Each requester offers one serial codeword at a time.
- The block picks a winner and drives the decoder's start and data_in for exactly N cycles.
- It records the winner's index in a tag FIFO.
- It routes each K-bit decoded frame back to the requester that supplied the codeword.
- It sits between the channel front-ends and the decoder instance.

---
 rtl/bch_arb_pkg.sv | 28 ++
 rtl/bch_arb_tag_fifo.sv | 62 ++++++
 rtl/bch_decode_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bch_arb_pkg.sv
// Shared types, widths and helpers for the BCH decoder arbiter.
package bch_arb_pkg;

    // ceil(log2(value)), never less than 1 so every counter keeps at least one bit
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int N_DEF         = 15;
    localparam int K_DEF         = 5;
    localparam int R_DEF         = 4;
    localparam int TAG_DEPTH_DEF = 4;

    localparam int TW = clog2(R_DEF);
    localparam int CW = clog2(N_DEF);
    localparam int OW = clog2(K_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/bch_arb_tag_fifo.sv
// Tag FIFO remembering which requester owns each codeword inside the decoder.
module bch_arb_tag_fifo
    import bch_arb_pkg::*;
#(
    parameter int TAG_W = TW,
    parameter int DEPTH = TAG_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [TAG_W-1:0] head
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot being refilled, so push is legal when full and popping.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

endmodule

// File: rtl/bch_decode_arbiter.sv
// Shares one serial BCH decoder between R requesters and steers decoded frames back.
// Build option: define BCH_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module bch_decode_arbiter
    import bch_arb_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int K         = K_DEF,
    parameter int R         = R_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [R-1:0] req,
    input  logic [R-1:0] data_in,
    output logic [R-1:0] grant,
    output logic [R-1:0] frame_sent,
    output logic [R-1:0] out_valid,
    output logic         out_data,
    output logic [R-1:0] frame_done,
    output logic         orphan_err,
    output logic         dec_start,
    output logic         dec_data_in,
    input  logic         dec_busy,
    input  logic         dec_output_valid,
    input  logic         dec_data_out,
    output state_t       dbg_state
);

    localparam int TAG_W = clog2(R);
    localparam int CNT_W = clog2(N);
    localparam int OBIT_W = clog2(K);
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(N - 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N - 1);
    localparam logic [OBIT_W-1:0] OBIT_LAST = OBIT_W'(K - 1);
    localparam logic [R-1:0]      ONE_HOT   = R'(1);

    // Handshake: req[i] is a level held until grant[i] rises; grant[i] stays high for
    // exactly N consecutive cycles and requester i drives bit j while the bit counter is j.

    state_t             state;
    logic [TAG_W-1:0]   sel;
    logic [CNT_W-1:0]   cnt;
    logic [OBIT_W-1:0]  obit;
    logic [TAG_W-1:0]   pick;
    logic               pick_valid;
    logic               tag_full;
    logic               tag_empty;
    logic [TAG_W-1:0]   tag_head;
    logic               tag_push;
    logic               tag_pop;
    logic               owned;
    logic               start_ok;

`ifdef BCH_ARB_ROUND_ROBIN_EN
    logic [TAG_W-1:0] rr_ptr;

    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < R; i++) begin
            if (!pick_valid && req[(int'(rr_ptr) + i) % R]) begin
                pick       = TAG_W'((int'(rr_ptr) + i) % R);
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (start_ok) begin
            rr_ptr <= (int'(pick) == R - 1) ? '0 : pick + 1'b1;
        end
    end
`else
    // Walk from the top down so the lowest requesting index is the last one written.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = R - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick       = TAG_W'(i);
                pick_valid = 1'b1;
            end
        end
    end
`endif

    assign start_ok  = (state == IDLE) && pick_valid && !dec_busy && !tag_full;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= '0;
            cnt        <= '0;
            dec_start  <= 1'b0;
            frame_sent <= '0;
        end else begin
            dec_start  <= 1'b0;
            frame_sent <= '0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        sel       <= pick;
                        cnt       <= '0;
                        dec_start <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // Registered pulse lines up with the N-th bit on the following cycle.
                    if (cnt == CNT_PRE) begin
                        frame_sent <= ONE_HOT << sel;
                    end
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign grant       = (state == SEND) ? (ONE_HOT << sel) : '0;
    assign dec_data_in = (state == SEND) ? data_in[sel] : 1'b0;
    assign tag_push    = (state == SEND) && (cnt == '0);

    bch_arb_tag_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tag_push),
        .push_tag (sel),
        .pop      (tag_pop),
        .full     (tag_full),
        .empty    (tag_empty),
        .head     (tag_head)
    );

    assign owned     = dec_output_valid && !tag_empty;
    assign tag_pop   = owned && (obit == OBIT_LAST);
    assign out_valid = owned ? (ONE_HOT << tag_head) : '0;
    assign out_data  = dec_data_out;

    // frame_done is registered, so it follows the K-th decoded bit by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            obit       <= '0;
            frame_done <= '0;
            orphan_err <= 1'b0;
        end else begin
            frame_done <= tag_pop ? (ONE_HOT << tag_head) : '0;
            if (owned) begin
                obit <= (obit == OBIT_LAST) ? '0 : obit + 1'b1;
            end
            if (dec_output_valid && tag_empty) begin
                orphan_err <= 1'b1;
            end
        end
    end

endmodule
